// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a 2-entry skid, registered in_ready, flush, and bubble-zeroed control.
// Optional perf counters (stall_cnt, bubble_cnt) are present only when PIPE_PERF_CNT_EN is defined.
module pipe_stage_skid #(
    parameter int DATA_W = 166,
    parameter int CTRL_W = 10
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_BUSY  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_in_ready;
    logic [DATA_W-1:0]   r_main_data;
    logic [CTRL_W-1:0]   r_main_ctrl;
    logic [DATA_W-1:0]   r_skid_data;
    logic [CTRL_W-1:0]   r_skid_ctrl;

    logic                w_push;
    logic                w_pop;
    logic                w_out_valid;
    logic                w_load_main_in;
    logic                w_load_main_skid;
    logic                w_load_skid;

    assign w_out_valid = (r_state != S_EMPTY);
    assign w_push      = in_valid & r_in_ready;
    assign w_pop       = w_out_valid & out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_push) begin
                    w_state_nxt    = S_BUSY;
                    w_load_main_in = 1'b1;
                end
            end
            S_BUSY: begin
                if (w_push && !w_pop) begin
                    w_state_nxt = S_FULL;
                    w_load_skid = 1'b1;
                end else if (w_push && w_pop) begin
                    w_load_main_in = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_pop) begin
                    w_state_nxt      = S_BUSY;
                    w_load_main_skid = 1'b1;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    // Flush kills both entries and zeroes their control; payload regs may keep stale data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_in_ready  <= 1'b1;
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else if (flush) begin
            r_state     <= S_EMPTY;
            r_in_ready  <= 1'b1;
            r_main_ctrl <= '0;
            r_skid_ctrl <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != S_FULL);
            if (w_load_main_in) begin
                r_main_data <= in_data;
                r_main_ctrl <= in_ctrl;
            end else if (w_load_main_skid) begin
                r_main_data <= r_skid_data;
                r_main_ctrl <= r_skid_ctrl;
            end
            if (w_load_skid) begin
                r_skid_data <= in_data;
                r_skid_ctrl <= in_ctrl;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_main_data;
    assign out_ctrl  = w_out_valid ? r_main_ctrl : '0;

`ifdef PIPE_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    // Saturating counters; flush deliberately leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_out_valid && !out_ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (!w_out_valid && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed stimulus with a queue scoreboard; an independent negedge monitor checks every output beat.
module tb_pipe_stage_skid;
    localparam int DW = 16;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
`ifdef PIPE_PERF_CNT_EN
    logic [3:0]    stall_cnt;
    logic [3:0]    bubble_cnt;
`endif

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .DATA_W(DW),
        .CTRL_W(CW)
`ifdef PIPE_PERF_CNT_EN
        ,
        .CNT_W(4)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    int                  checks   = 0;
    int                  failures = 0;
    logic [DW+CW-1:0]    exp_q[$];
    logic                mon_en   = 1'b0;
    logic                hold_vld = 1'b0;
    logic [DW+CW-1:0]    hold_beat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on each downstream transfer, checks bubbles and hold stability.
    always @(negedge clk) begin : monitor
        logic [DW+CW-1:0] beat;
        if (mon_en) begin
            if (out_valid) begin
                if (hold_vld) chk("hold_stable", {6'd0, out_data, out_ctrl}, {6'd0, hold_beat});
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat: got %0h expected none at %0t", {out_data, out_ctrl}, $time);
                    end else begin
                        beat = exp_q.pop_front();
                        chk("beat", {6'd0, out_data, out_ctrl}, {6'd0, beat});
                    end
                end
            end else begin
                chk("bubble_ctrl", {22'd0, out_ctrl}, 32'd0);
            end
            hold_vld  = out_valid && !out_ready && !flush && !rst;
            hold_beat = {out_data, out_ctrl};
            if (flush || rst) exp_q.delete();
        end
    end

    // One cycle of stimulus; erdy/eov are the hand-computed in_ready/out_valid for this cycle.
    task automatic step(input logic r, input logic f, input logic v,
                        input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input logic ordy, input logic erdy, input logic eov);
        rst       = r;
        flush     = f;
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        @(negedge clk);
        chk("in_ready", {31'd0, in_ready}, {31'd0, erdy});
        chk("out_valid", {31'd0, out_valid}, {31'd0, eov});
        if (v && erdy && !r && !f) exp_q.push_back({d, c});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 16'h00AA; in_ctrl = '1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // reset held a second cycle with in_valid high: nothing may be captured
        step(1, 0, 1, 16'h00AA, 10'h3FF, 0, 1, 0);
        chk("rst_out_data", {16'd0, out_data}, 32'd0);
        step(0, 0, 0, 16'h0000, 10'h000, 1, 1, 0);

        // back-to-back stream with out_ready=1
        step(0, 0, 1, 16'h0001, 10'h001, 1, 1, 0);
        for (int i = 2; i <= 5; i++) step(0, 0, 1, 16'(i), 10'(i), 1, 1, 1);
        step(0, 0, 0, 16'h0000, 10'h000, 1, 1, 1);
        step(0, 0, 0, 16'h0000, 10'h000, 1, 1, 0);

        // fill skid, hold C off for three cycles, then drain A, B, C
        step(0, 0, 1, 16'h000A, 10'h155, 0, 1, 0);
        step(0, 0, 1, 16'h000B, 10'h0AA, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 16'h000C, 10'h3C3, 0, 0, 1);
        step(0, 0, 1, 16'h000C, 10'h3C3, 1, 0, 1);
        step(0, 0, 1, 16'h000C, 10'h3C3, 1, 1, 1);
        step(0, 0, 0, 16'h0000, 10'h000, 1, 1, 1);
        step(0, 0, 0, 16'h0000, 10'h000, 0, 1, 0);

        // flush while FULL with a pending push
        step(0, 0, 1, 16'h000D, 10'h3FF, 0, 1, 0);
        step(0, 0, 1, 16'h000E, 10'h3FF, 0, 1, 1);
        step(0, 1, 1, 16'h000F, 10'h3FF, 0, 0, 1);
        step(0, 0, 0, 16'h0000, 10'h000, 1, 1, 0);
        step(0, 0, 0, 16'h0000, 10'h000, 1, 1, 0);

        // flush coinciding with a pop: the pop still completes, the push is dropped
        step(0, 0, 1, 16'h0011, 10'h3FF, 1, 1, 0);
        step(0, 1, 1, 16'h0012, 10'h3FF, 1, 1, 1);
        step(0, 0, 0, 16'h0000, 10'h000, 1, 1, 0);

        // all-ones ctrl visible for exactly one cycle
        step(0, 0, 1, 16'h0055, 10'h3FF, 1, 1, 0);
        step(0, 0, 0, 16'h0000, 10'h000, 1, 1, 1);
        step(0, 0, 0, 16'h0000, 10'h000, 1, 1, 0);

        // reset while FULL drops both entries
        step(0, 0, 1, 16'h0021, 10'h001, 0, 1, 0);
        step(0, 0, 1, 16'h0022, 10'h002, 0, 1, 1);
        step(1, 0, 1, 16'h0023, 10'h003, 0, 0, 1);
        step(0, 0, 0, 16'h0000, 10'h000, 1, 1, 0);
        step(0, 0, 0, 16'h0000, 10'h000, 1, 1, 0);

`ifdef PIPE_PERF_CNT_EN
        step(1, 0, 0, 16'h0000, 10'h000, 0, 1, 0);
        step(0, 0, 1, 16'h0031, 10'h005, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 16'h0000, 10'h000, 0, 1, 1);
        chk("stall_cnt_3", {28'd0, stall_cnt}, 32'd3);
        chk("bubble_cnt_1", {28'd0, bubble_cnt}, 32'd1);
        for (int i = 0; i < 17; i++) step(0, 0, 0, 16'h0000, 10'h000, 0, 1, 1);
        chk("stall_cnt_sat", {28'd0, stall_cnt}, 32'd15);
        step(0, 0, 0, 16'h0000, 10'h000, 1, 1, 1);
        step(0, 0, 0, 16'h0000, 10'h000, 1, 1, 0);
        chk("bubble_cnt_2", {28'd0, bubble_cnt}, 32'd2);
        chk("stall_cnt_hold", {28'd0, stall_cnt}, 32'd15);
`endif

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
